muldiv_seq: RTL and testbench

MULDIV_SEQ -- requirements
Module: muldiv_seq

---
 rtl/muldiv_seq.sv | 233 +++++++++++++++++++++++
 tb/tb_muldiv_seq.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// muldiv_seq: fixed-latency multiply / multiply-accumulate / divide unit
// writing a HI/LO register pair, with flush and direct HI/LO writes.
module muldiv_seq #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             w,
  input  logic             w_sel,
  output logic             busy,
  output logic             done,
  output logic             dbz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int DW      = 2 * WIDTH;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [2:0]       op_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] lat_s;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic             done_r;
  logic             dbz_r;
  logic             last_s;
  logic             accept_s;
  logic             commit_s;
  logic             wr_s;
  logic             is_div_s;
  logic [DW-1:0]    prod_s;
  logic [DW-1:0]    quot_rem_s;
  logic [DW-1:0]    acc_s;
  logic [DW-1:0]    res_s;

  // Full-width product; operands sign-extended when sgn is set, result mod 2^DW.
  function automatic logic [DW-1:0] mul_full(input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y,
                                             input logic             sgn);
    logic [DW-1:0] xe;
    logic [DW-1:0] ye;
    xe = {{WIDTH{sgn & x[WIDTH-1]}}, x};
    ye = {{WIDTH{sgn & y[WIDTH-1]}}, y};
    return xe * ye;
  endfunction

  // Returns {remainder, quotient}; signed results are built from magnitudes so
  // the quotient truncates toward zero and the remainder follows the dividend.
  function automatic logic [DW-1:0] div_full(input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y,
                                             input logic             sgn);
    logic             neg_x;
    logic             neg_y;
    logic [WIDTH-1:0] mx;
    logic [WIDTH-1:0] my;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    neg_x = sgn & x[WIDTH-1];
    neg_y = sgn & y[WIDTH-1];
    mx    = neg_x ? -x : x;
    my    = neg_y ? -y : y;
    if (y == {WIDTH{1'b0}}) begin
      q = {WIDTH{1'b1}};
      r = x;
    end else if (sgn && (x == MIN_VAL) && (y == {WIDTH{1'b1}})) begin
      q = x;
      r = {WIDTH{1'b0}};
    end else begin
      q = mx / my;
      r = mx % my;
      if (neg_x ^ neg_y) begin
        q = -q;
      end else begin
        q = q;
      end
      if (neg_x) begin
        r = -r;
      end else begin
        r = r;
      end
    end
    return {r, q};
  endfunction

  assign last_s = (cnt_r == CNT_W'(1));
  assign busy   = (state_r == ST_RUN);
  assign done   = done_r;
  assign dbz    = dbz_r;
  assign hi     = hi_r;
  assign lo     = lo_r;

  // Latency selected from the incoming opcode at accept time.
  always_comb begin
    lat_s = (op[2:1] == 2'b01) ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; flush always returns to idle, even on the commit cycle.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start && !flush) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (flush || last_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM control outputs: accept, commit and direct-write strobes.
  always_comb begin
    accept_s = 1'b0;
    commit_s = 1'b0;
    wr_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        accept_s = start & ~flush;
        wr_s     = w & ~start;
      end
      ST_RUN: begin
        commit_s = ~flush & last_s;
      end
      default: begin
        accept_s = 1'b0;
        commit_s = 1'b0;
        wr_s     = 1'b0;
      end
    endcase
  end

  // Result datapath; accumulate ops read HI/LO as they stand at the commit edge.
  always_comb begin
    prod_s     = mul_full(a_r, b_r, ~op_r[0]);
    quot_rem_s = div_full(a_r, b_r, ~op_r[0]);
    acc_s      = {hi_r, lo_r};
    is_div_s   = (op_r[2:1] == 2'b01);
    case (op_r)
      3'b000, 3'b001: res_s = prod_s;
      3'b010, 3'b011: res_s = quot_rem_s;
      3'b100, 3'b101: res_s = acc_s + prod_s;
      3'b110, 3'b111: res_s = acc_s - prod_s;
      default:        res_s = prod_s;
    endcase
  end

  // Operand capture and latency counter; the counter stops at zero, never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r   <= {WIDTH{1'b0}};
      b_r   <= {WIDTH{1'b0}};
      op_r  <= 3'b000;
      cnt_r <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      a_r   <= a;
      b_r   <= b;
      op_r  <= op;
      cnt_r <= lat_s;
    end else if (busy) begin
      if (flush || last_s) begin
        cnt_r <= {CNT_W{1'b0}};
      end else begin
        cnt_r <= cnt_r - CNT_W'(1);
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Architectural HI/LO/dbz registers and the done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_r   <= {WIDTH{1'b0}};
      lo_r   <= {WIDTH{1'b0}};
      dbz_r  <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= commit_s;
      if (commit_s) begin
        hi_r <= res_s[DW-1:WIDTH];
        lo_r <= res_s[WIDTH-1:0];
        if (is_div_s) begin
          dbz_r <= (b_r == {WIDTH{1'b0}});
        end else begin
          dbz_r <= dbz_r;
        end
      end else if (wr_s) begin
        if (w_sel) begin
          hi_r <= a;
        end else begin
          lo_r <= a;
        end
      end else begin
        hi_r <= hi_r;
        lo_r <= lo_r;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: reference model feeds a scoreboard queue
// at issue time; entries are popped and compared when done pulses.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst, start, flush, w, w_sel;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done, dbz;
  logic [31:0] hi, lo;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_hi, m_lo;
  logic        m_dbz;

  muldiv_seq #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .w(w), .w_sel(w_sel),
    .busy(busy), .done(done), .dbz(dbz), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Reference model built on the language's own 64-bit and signed operators.
  function automatic void model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p, acc;
    acc = {m_hi, m_lo};
    if (o[0]) p = {32'd0, x} * {32'd0, y};
    else      p = 64'(longint'($signed(x)) * longint'($signed(y)));
    case (o)
      3'b010, 3'b011: begin
        if (y == 32'd0) begin
          m_lo = 32'hFFFF_FFFF; m_hi = x; m_dbz = 1'b1;
        end else if (o == 3'b010 && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          m_lo = x; m_hi = 32'd0; m_dbz = 1'b0;
        end else if (o == 3'b010) begin
          m_lo = 32'($signed(x) / $signed(y)); m_hi = 32'($signed(x) % $signed(y)); m_dbz = 1'b0;
        end else begin
          m_lo = x / y; m_hi = x % y; m_dbz = 1'b0;
        end
      end
      3'b100, 3'b101: {m_hi, m_lo} = acc + p;
      3'b110, 3'b111: {m_hi, m_lo} = acc - p;
      default:        {m_hi, m_lo} = p;
    endcase
  endfunction

  // Drive one start cycle; returns #1 after the accept edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input bit expect_commit);
    exp_t e;
    start = 1'b1; op = o; a = x; b = y;
    if (expect_commit) begin
      model(o, x, y);
      e.hi = m_hi; e.lo = m_lo; e.dbz = m_dbz;
      e.lat = (o[2:1] == 2'b01) ? 10 : 5;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic hl_write(input logic sel, input logic [31:0] val);
    w = 1'b1; w_sel = sel; a = val;
    @(posedge clk); #1;
    w = 1'b0;
    if (sel) m_hi = val; else m_lo = val;
  endtask

  // Wait (bounded) for done and pop the matching scoreboard entry.
  task automatic collect(input int budget, output int cyc, output logic early_idle, output exp_t e);
    cyc = -1; early_idle = 1'b0;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk); #1;
      if (done) begin cyc = i; break; end
      if (!busy) early_idle = 1'b1;
    end
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else begin e.hi = 32'd0; e.lo = 32'd0; e.dbz = 1'b0; e.lat = -2; end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; w = 1'b1; flush = 1'b1; a = 32'h1234_5678; op = 3'b000;
    repeat (2) @(posedge clk); #1;
    rst = 1'b0; start = 1'b0; w = 1'b0; flush = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0; m_dbz = 1'b0;
    checks++; if (hi !== 32'd0)  begin failures++; $display("FAIL reset_hi got=%h want=0", hi); end
    checks++; if (lo !== 32'd0)  begin failures++; $display("FAIL reset_lo got=%h want=0", lo); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
    checks++; if (dbz !== 1'b0)  begin failures++; $display("FAIL reset_dbz got=%b want=0", dbz); end
  endtask

  task automatic test_mult();
    logic [2:0] ops[4] = '{3'b000, 3'b001, 3'b000, 3'b001};
    logic [31:0] xs[4] = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'h8000_0000, 32'hDEAD_BEEF};
    logic [31:0] ys[4] = '{32'd3, 32'd3, 32'h8000_0000, 32'hFFFF_FFFF};
    int cyc; logic early; exp_t e;
    for (int k = 0; k < 4; k++) begin
      issue(ops[k], xs[k], ys[k], 1'b1);
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mult%0d_busy got=%b want=1", k, busy); end
      collect(20, cyc, early, e);
      checks++; if (cyc !== e.lat) begin failures++; $display("FAIL mult%0d_latency got=%0d want=%0d", k, cyc, e.lat); end
      checks++; if (early) begin failures++; $display("FAIL mult%0d_busy_early got=idle want=busy", k); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mult%0d_busy_after got=%b want=0", k, busy); end
      checks++; if ({hi, lo} !== {e.hi, e.lo}) begin failures++; $display("FAIL mult%0d_result got=%h_%h want=%h_%h", k, hi, lo, e.hi, e.lo); end
      @(posedge clk); #1;
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL mult%0d_done_pulse got=%b want=0", k, done); end
    end
  endtask

  task automatic test_div();
    logic [2:0] ops[6] = '{3'b010, 3'b011, 3'b011, 3'b010, 3'b010, 3'b011};
    logic [31:0] xs[6] = '{32'hFFFF_FFF9, 32'd7, 32'd5, 32'h8000_0000, 32'd7, 32'hFFFF_FFFF};
    logic [31:0] ys[6] = '{32'd2, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd16};
    int cyc; logic early; exp_t e;
    for (int k = 0; k < 6; k++) begin
      issue(ops[k], xs[k], ys[k], 1'b1);
      collect(20, cyc, early, e);
      checks++; if (cyc !== e.lat) begin failures++; $display("FAIL div%0d_latency got=%0d want=%0d", k, cyc, e.lat); end
      checks++; if (early) begin failures++; $display("FAIL div%0d_busy_early got=idle want=busy", k); end
      checks++; if ({hi, lo} !== {e.hi, e.lo}) begin failures++; $display("FAIL div%0d_result got=%h_%h want=%h_%h", k, hi, lo, e.hi, e.lo); end
      checks++; if (dbz !== e.dbz) begin failures++; $display("FAIL div%0d_dbz got=%b want=%b", k, dbz, e.dbz); end
    end
  endtask

  task automatic test_accumulate();
    int cyc; logic early; exp_t e;
    hl_write(1'b0, 32'hFFFF_FFFF);
    checks++; if ({hi, lo} !== {m_hi, m_lo}) begin failures++; $display("FAIL write_lo got=%h_%h want=%h_%h", hi, lo, m_hi, m_lo); end
    hl_write(1'b1, 32'd0);
    checks++; if ({hi, lo} !== {m_hi, m_lo}) begin failures++; $display("FAIL write_hi got=%h_%h want=%h_%h", hi, lo, m_hi, m_lo); end
    issue(3'b101, 32'd1, 32'd1, 1'b1);
    collect(20, cyc, early, e);
    checks++; if ({hi, lo} !== {e.hi, e.lo}) begin failures++; $display("FAIL maddu_result got=%h_%h want=%h_%h", hi, lo, e.hi, e.lo); end
    w = 1'b1; w_sel = 1'b0;
    issue(3'b110, 32'd1, 32'd1, 1'b1);
    w = 1'b0;
    collect(20, cyc, early, e);
    checks++; if ({hi, lo} !== {e.hi, e.lo}) begin failures++; $display("FAIL msub_start_wins got=%h_%h want=%h_%h", hi, lo, e.hi, e.lo); end
    issue(3'b100, 32'hFFFF_FFF0, 32'd3, 1'b1);
    collect(20, cyc, early, e);
    checks++; if ({hi, lo} !== {e.hi, e.lo}) begin failures++; $display("FAIL madd_result got=%h_%h want=%h_%h", hi, lo, e.hi, e.lo); end
    issue(3'b111, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1);
    collect(20, cyc, early, e);
    checks++; if ({hi, lo} !== {e.hi, e.lo}) begin failures++; $display("FAIL msubu_result got=%h_%h want=%h_%h", hi, lo, e.hi, e.lo); end
  endtask

  task automatic test_busy_ignore();
    int cyc; logic early; logic saw; exp_t e;
    issue(3'b000, 32'd3, 32'hFFFF_FFFC, 1'b1);
    @(posedge clk); #1;
    start = 1'b1; op = 3'b011; a = 32'd100; b = 32'd7; w = 1'b1; w_sel = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; w = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ignore_busy got=%b want=1", busy); end
    collect(20, cyc, early, e);
    checks++; if (cyc !== e.lat - 2) begin failures++; $display("FAIL ignore_latency got=%0d want=%0d", cyc, e.lat - 2); end
    checks++; if ({hi, lo} !== {e.hi, e.lo}) begin failures++; $display("FAIL ignore_result got=%h_%h want=%h_%h", hi, lo, e.hi, e.lo); end
    saw = 1'b0;
    repeat (12) begin @(posedge clk); #1; if (busy || done) saw = 1'b1; end
    checks++; if (saw !== 1'b0) begin failures++; $display("FAIL ignore_no_restart got=activity want=idle"); end
  endtask

  task automatic test_flush();
    logic saw;
    hl_write(1'b0, 32'h1234_5678);
    hl_write(1'b1, 32'h9ABC_DEF0);
    issue(3'b000, 32'd5, 32'd5, 1'b0);
    repeat (2) @(posedge clk); #1;
    flush = 1'b1; @(posedge clk); #1; flush = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_busy got=%b want=0", busy); end
    saw = 1'b0;
    repeat (8) begin @(posedge clk); #1; if (done || busy) saw = 1'b1; end
    checks++; if (saw !== 1'b0) begin failures++; $display("FAIL flush_no_done got=activity want=idle"); end
    checks++; if ({hi, lo} !== {m_hi, m_lo}) begin failures++; $display("FAIL flush_hilo got=%h_%h want=%h_%h", hi, lo, m_hi, m_lo); end
    issue(3'b001, 32'd7, 32'd9, 1'b0);
    repeat (4) @(posedge clk); #1;
    flush = 1'b1; @(posedge clk); #1; flush = 1'b0;
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL flush_at_commit got=done%b_busy%b want=done0_busy0", done, busy); end
    checks++; if ({hi, lo} !== {m_hi, m_lo}) begin failures++; $display("FAIL flush_at_commit_hilo got=%h_%h want=%h_%h", hi, lo, m_hi, m_lo); end
    issue(3'b011, 32'd10, m_dbz ? 32'd3 : 32'd0, 1'b0);
    flush = 1'b1; @(posedge clk); #1; flush = 1'b0;
    repeat (12) @(posedge clk); #1;
    checks++; if (dbz !== m_dbz) begin failures++; $display("FAIL flush_dbz got=%b want=%b", dbz, m_dbz); end
    start = 1'b1; op = 3'b000; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_start_idle got=%b want=0", busy); end
  endtask

  task automatic test_rst_inflight();
    logic saw;
    hl_write(1'b0, 32'hCAFE_0001);
    hl_write(1'b1, 32'h0BAD_0002);
    issue(3'b010, 32'd100, 32'd0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0; m_dbz = 1'b0;
    checks++; if ({hi, lo} !== 64'd0) begin failures++; $display("FAIL rst_hilo got=%h_%h want=0_0", hi, lo); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0 || dbz !== 1'b0) begin failures++; $display("FAIL rst_done_dbz got=%b%b want=00", done, dbz); end
    saw = 1'b0;
    repeat (14) begin @(posedge clk); #1; if (done || busy || dbz || hi != 32'd0 || lo != 32'd0) saw = 1'b1; end
    checks++; if (saw !== 1'b0) begin failures++; $display("FAIL rst_no_commit got=activity want=idle"); end
  endtask

  task automatic test_back_to_back();
    int cyc; logic early; exp_t e;
    logic [2:0] o; logic [31:0] x, y;
    for (int k = 0; k < 24; k++) begin
      o = 3'($urandom_range(0, 7));
      x = $urandom;
      case ($urandom_range(0, 3))
        0: y = 32'd0;
        1: y = 32'($urandom_range(1, 9));
        default: y = $urandom;
      endcase
      issue(o, x, y, 1'b1);
      checks++; if (busy !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL b2b%0d_accept got=busy%b_done%b want=busy1_done0", k, busy, done); end
      collect(20, cyc, early, e);
      checks++; if (cyc !== e.lat) begin failures++; $display("FAIL b2b%0d_latency op=%b got=%0d want=%0d", k, o, cyc, e.lat); end
      checks++; if ({hi, lo, dbz} !== {e.hi, e.lo, e.dbz}) begin failures++; $display("FAIL b2b%0d_result op=%b a=%h b=%h got=%h_%h_%b want=%h_%h_%b", k, o, x, y, hi, lo, dbz, e.hi, e.lo, e.dbz); end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; w = 1'b0; w_sel = 1'b0;
    op = 3'b000; a = 32'd0; b = 32'd0;
    m_hi = 32'd0; m_lo = 32'd0; m_dbz = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_mult();
    test_div();
    test_accumulate();
    test_busy_ignore();
    test_flush();
    test_rst_inflight();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
